// File: rtl/gray_window_gen_pkg.sv
// Widths, types and ring-select helper shared by the gray 3x3 window generator.
package gray_window_gen_pkg;

`include "cnn_defines.v"

    localparam int unsigned DATA_W    = `CNN_DATA_IN_W;
    localparam int unsigned ADDR_W    = `CNN_GRAY_BUFFER_ADDR_W;
    localparam int unsigned WIN_SIZE  = `CNN_WIN_SIZE;
    localparam int unsigned WIN_ELEMS = WIN_SIZE * WIN_SIZE;
    localparam int unsigned NUM_LINES = 3;

    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [1:0]        buf_sel_t;

    // (sel + off) mod 3 over the three line buffers
    function automatic buf_sel_t ring_add(input buf_sel_t sel, input buf_sel_t off);
        logic [2:0] sum;
        sum = {1'b0, sel} + {1'b0, off};
        if (sum >= 3'd3)
            return buf_sel_t'(sum - 3'd3);
        return sum[1:0];
    endfunction

endpackage

// File: rtl/cnn_defines.v
// Shared CNN datapath widths and the convolution window size.
`ifndef CNN_DEFINES_V
`define CNN_DEFINES_V
`define CNN_DATA_IN_W          8
`define CNN_GRAY_BUFFER_ADDR_W 8
`define CNN_WIN_SIZE           3
`endif

// File: rtl/gray_window_gen_line_mem.sv
// One image-row line buffer: synchronous write port plus registered read port
// whose output holds while rd_en is low.
module gray_line_mem
    import gray_window_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 25
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] unused_addr;

    // addresses never exceed DEPTH-1, so only the low index bits are decoded
    assign unused_addr = wr_addr ^ rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr[IDX_W-1:0]];
    end

endmodule

// File: rtl/gray_window_gen.sv
// Streams a raster gray image and emits stride-1 unpadded 3x3 windows with
// valid/ready handshakes on both sides.
module gray_window_gen
    import gray_window_gen_pkg::*;
#(
    parameter int unsigned IMG_IN_WIDTH  = 25,
    parameter int unsigned IMG_IN_HEIGHT = 25
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [DATA_W-1:0]           pix_data,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [WIN_ELEMS*DATA_W-1:0] win_data,
    output logic                        frame_done
);

    localparam int unsigned ROW_W = (IMG_IN_HEIGHT > 1) ? $clog2(IMG_IN_HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] COL_LAST      = ADDR_W'(IMG_IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(IMG_IN_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] COL_FIRST_WIN = ADDR_W'(WIN_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST_WIN = ROW_W'(WIN_SIZE - 1);

    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    buf_sel_t          wr_sel;
    buf_sel_t          top_sel;
    buf_sel_t          mid_sel;

    logic              pix_hs;
    logic              s2_adv;
    logic              col_wrap;
    logic              frame_end;

    logic              s1_valid;
    logic              s1_win;
    logic              s1_last;
    pix_t              s1_pix;
    buf_sel_t          s1_top_sel;
    buf_sel_t          s1_mid_sel;

    pix_t              rd_data [NUM_LINES];
    pix_t              col_in  [WIN_SIZE];
    pix_t              win_px  [WIN_ELEMS];
    logic              win_last;

    assign s2_adv     = !win_valid || win_ready;
    assign pix_ready  = !s1_valid || s2_adv;
    assign pix_hs     = pix_valid && pix_ready;
    assign col_wrap   = (col == COL_LAST);
    assign frame_end  = col_wrap && (row == ROW_LAST);
    assign top_sel    = ring_add(wr_sel, 2'd1);
    assign mid_sel    = ring_add(wr_sel, 2'd2);
    assign frame_done = win_valid && win_ready && win_last;

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_line
        gray_line_mem #(
            .DEPTH (IMG_IN_WIDTH)
        ) u_line_mem (
            .clk     (clk),
            .wr_en   (pix_hs && (wr_sel == buf_sel_t'(b))),
            .wr_addr (col),
            .wr_data (pix_data),
            .rd_en   (pix_hs && (wr_sel != buf_sel_t'(b))),
            .rd_addr (col),
            .rd_data (rd_data[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            wr_sel <= '0;
        end else if (pix_hs) begin
            if (col_wrap) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row    <= '0;
                    wr_sel <= '0;
                end else begin
                    row    <= row + ROW_W'(1);
                    wr_sel <= ring_add(wr_sel, 2'd1);
                end
            end else begin
                col <= col + ADDR_W'(1);
            end
        end
    end

    // Stage 1: the accepted pixel waits here alongside its line-buffer reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_win     <= 1'b0;
            s1_last    <= 1'b0;
            s1_pix     <= '0;
            s1_top_sel <= '0;
            s1_mid_sel <= '0;
        end else if (pix_hs) begin
            s1_valid   <= 1'b1;
            s1_win     <= (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
            s1_last    <= frame_end;
            s1_pix     <= pix_data;
            s1_top_sel <= top_sel;
            s1_mid_sel <= mid_sel;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        col_in[0] = rd_data[s1_top_sel];
        col_in[1] = rd_data[s1_mid_sel];
        col_in[2] = s1_pix;
    end

    // Stage 2: every stage-1 pixel shifts a column in, windowed or not,
    // so border columns never leave stale data behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_px    <= '{default: '0};
        end else if (s2_adv) begin
            win_valid <= s1_valid && s1_win;
            win_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                for (int unsigned r = 0; r < WIN_SIZE; r++) begin
                    for (int unsigned c = 0; c < WIN_SIZE - 1; c++)
                        win_px[r*WIN_SIZE + c] <= win_px[r*WIN_SIZE + c + 1];
                    win_px[r*WIN_SIZE + WIN_SIZE - 1] <= col_in[r];
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < WIN_ELEMS; k++)
            win_data[k*DATA_W +: DATA_W] = win_px[k];
    end

endmodule

// File: tb/tb_gray_window_gen.sv
// Self-checking bench for gray_window_gen on a 5x5 image with random stalls/gaps.
module tb_gray_window_gen;
    import gray_window_gen_pkg::*;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int WB = WIN_ELEMS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data = '0;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic [WB-1:0]     win_data;
    logic              frame_done;

    gray_window_gen #(
        .IMG_IN_WIDTH  (W),
        .IMG_IN_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB-1:0] data;
        bit            last;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            stall_pct = 0;
    int            gap_pct = 0;
    exp_t          exp_q[$];
    int            win_cnt = 0;
    int            fd_cnt = 0;
    int            pix_acc = 0;
    int            first_win_pix = -1;
    bit            prev_stall = 0;
    logic [WB-1:0] prev_data = '0;
    int            img[H][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_win(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Window whose bottom-right pixel is (r,c), element k = 3*i+j in LSB-first order
    function automatic logic [WB-1:0] win_of(input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DATA_W +: DATA_W] = DATA_W'(img[r-2+i][c-2+j]);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (win_valid && first_win_pix < 0)
                first_win_pix = pix_acc;
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(win_valid), 32'd1);
                chk_win("stall_data_hold", win_data, prev_data);
            end
            if (win_valid && win_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_window: observed %0h expected no window", win_data);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_win("window", win_data, e.data);
                    chk("frame_done_on_hs", 32'(frame_done), 32'(e.last));
                end
                win_cnt++;
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
            if (frame_done)
                fd_cnt++;
            prev_stall = win_valid && !win_ready;
            prev_data  = win_data;
            if (pix_valid && pix_ready)
                pix_acc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        win_ready = ($urandom_range(0, 99) >= stall_pct);
    endtask

    // Offers npix pixels in raster order; a full frame also queues its expected windows
    task automatic send_frame(input int base, input bit rnd, input int npix);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? int'($urandom_range(0, 255)) : base + 5*r + c;
        if (npix == W*H) begin
            for (int r = 2; r < H; r++)
                for (int c = 2; c < W; c++) begin
                    exp_t e;
                    e.data = win_of(r, c);
                    e.last = (r == H-1) && (c == W-1);
                    exp_q.push_back(e);
                end
        end
        for (int p = 0; p < npix; p++) begin
            int  g;
            bit  acc;
            while ($urandom_range(0, 99) < gap_pct) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = DATA_W'(img[p / W][p % W]);
            g = 0;
            forever begin
                @(negedge clk);
                acc = pix_ready;
                tick();
                if (acc) break;
                g++;
                if (g > 500) begin
                    $display("FAIL pix_accept_timeout: observed pix_ready low 500 cycles, required acceptance");
                    $fatal(1, "pixel handshake timeout");
                end
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain(input int nwin, input int nframes);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || win_valid) && g < 2000) begin
            tick();
            g++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("win_count", 32'(win_cnt), 32'(nwin));
        chk("frame_done_count", 32'(fd_cnt), 32'(nframes));
    endtask

    task automatic start_test(input int stall, input int gap);
        stall_pct = stall;
        gap_pct   = gap;
        win_cnt   = 0;
        fd_cnt    = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_win_valid", 32'(win_valid), 32'd0);
        chk("in_reset_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("reset_win_valid", 32'(win_valid), 32'd0);
        chk("reset_pix_ready", 32'(pix_ready), 32'd1);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk_win("reset_win_data", win_data, '0);

        // Straight frame: the first window appears on the edge after the 13th
        // acceptance, which at full rate also accepts the 14th pixel
        start_test(0, 0);
        pix_acc = 0;
        first_win_pix = -1;
        send_frame(0, 0, W*H);
        wait_drain(9, 1);
        chk("first_window_latency", 32'(first_win_pix), 32'd14);

        start_test(30, 0);
        send_frame(0, 0, W*H);
        wait_drain(9, 1);

        start_test(0, 50);
        send_frame(0, 0, W*H);
        wait_drain(9, 1);

        start_test(0, 0);
        send_frame(0, 0, W*H);
        send_frame(100, 0, W*H);
        wait_drain(18, 2);

        start_test(30, 30);
        send_frame(0, 1, W*H);
        send_frame(0, 1, W*H);
        wait_drain(18, 2);

        // Abort a frame after 12 pixels with an asynchronous reset
        start_test(0, 0);
        send_frame(0, 0, 12);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("async_reset_win_valid", 32'(win_valid), 32'd0);
        chk("async_reset_pix_ready", 32'(pix_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        start_test(30, 30);
        send_frame(0, 1, W*H);
        wait_drain(9, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
